// File: rtl/uart_tx_framer.sv
// Asynchronous serial transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Every output is registered. The FSM state is exposed on o_state for observation.
module uart_tx_framer #(
    parameter int BAUD_DIV   = 434,
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              tx,
    output logic              busy,
    output logic              tx_done,
    output logic [2:0]        o_state
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(BAUD_DIV - 2);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic             ODD_FLIP  = (PARITY_ODD != 0);
    localparam logic             HAS_PAR   = (PARITY_EN != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_stop_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;

    logic [2:0]        w_state;
    logic [CNT_W-1:0]  w_cnt;
    logic [IDX_W-1:0]  w_idx;
    logic              w_stop_idx;
    logic [DATA_W-1:0] w_shift;
    logic              w_par;
    logic              w_tx;
    logic              w_busy;
    logic              w_done;
    logic              w_cnt_last;
    logic              w_stop_end;

    assign w_cnt_last = (r_cnt == CNT_LAST);
    // The frame hands back to IDLE one cycle before the last stop bit ends, so that
    // cycle carries tx_done with busy low and a new start launches with no idle gap.
    assign w_stop_end = (r_stop_idx == STOP_LAST) && (r_cnt == CNT_END);

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_idx      = r_idx;
        w_stop_idx = r_stop_idx;
        w_shift    = r_shift;
        w_par      = r_par;
        w_tx       = r_tx;
        w_busy     = r_busy;
        w_done     = 1'b0;

        if (r_state == S_IDLE) begin
            w_cnt = '0;
        end else begin
            w_cnt = w_cnt_last ? '0 : r_cnt + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_tx   = 1'b1;
                w_busy = 1'b0;
                if (start) begin
                    w_shift    = data;
                    w_par      = (^data) ^ ODD_FLIP;
                    w_idx      = '0;
                    w_stop_idx = 1'b0;
                    w_state    = S_START;
                    w_tx       = 1'b0;
                    w_busy     = 1'b1;
                end
            end
            S_START: begin
                if (w_cnt_last) begin
                    w_state = S_DATA;
                    w_tx    = r_shift[0];
                    w_idx   = '0;
                end
            end
            S_DATA: begin
                if (w_cnt_last) begin
                    if (r_idx == IDX_LAST) begin
                        if (HAS_PAR) begin
                            w_state = S_PARITY;
                            w_tx    = r_par;
                        end else begin
                            w_state = S_STOP;
                            w_tx    = 1'b1;
                        end
                    end else begin
                        w_idx   = r_idx + 1'b1;
                        w_shift = r_shift >> 1;
                        w_tx    = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_cnt_last) begin
                    w_state = S_STOP;
                    w_tx    = 1'b1;
                end
            end
            S_STOP: begin
                if (w_stop_end) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else if (w_cnt_last) begin
                    w_stop_idx = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_cnt   = '0;
                w_tx    = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_idx      <= w_idx;
            r_stop_idx <= w_stop_idx;
            r_shift    <= w_shift;
            r_par      <= w_par;
            r_tx       <= w_tx;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

    assign tx      = r_tx;
    assign busy    = r_busy;
    assign tx_done = r_done;
    assign o_state = r_state;

endmodule
